// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared definitions for the PWM duty sequencer.
// Holds the FSM state encoding, the duty-level width and the default upper
// duty bound. The bound matches the 10-step PWM core: 0..10 in 10% steps.
package pwm_duty_sequencer_pkg;

  localparam int DUTY_W       = 4;
  localparam int MAX_DUTY_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_WAIT = 2'd1,
    ST_REPEAT    = 2'd2,
    ST_RAMP      = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pwm_duty_sequencer_edge.sv
// step_edge_detect: registers a request level and flags its rising edge.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset (previous sample clears to 0)
//   level - request level, already synchronous to clk
//   rise  - high while level=1 and the previously sampled level was 0
module step_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  // The strobe is combinational so the sequencer samples the edge on the
  // same clock that first sees the new level.
  assign rise = level & ~prev_q;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: drives the step inputs of the 10-step PWM core.
// Button levels become single-cycle step pulses with auto-repeat while held;
// a programmed target duty is approached one step per STEP_CYCLES clocks.
// A shadow copy of the PWM duty level keeps pulses from going past the bounds.
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-high reset
//   inc_req      - debounced increase-button level
//   dec_req      - debounced decrease-button level
//   target_valid - one-cycle strobe that loads target_duty
//   target_duty  - requested duty level (clamped to MAX_DUTY)
//   inc_pulse    - one-cycle step-up pulse to the PWM
//   dec_pulse    - one-cycle step-down pulse to the PWM
//   duty_level   - shadow duty level
//   busy         - high whenever the sequencer is not idle
//   at_max       - duty_level equals MAX_DUTY
//   at_min       - duty_level equals 0
module pwm_duty_sequencer
  import pwm_duty_sequencer_pkg::*;
#(
  parameter int INITIAL_DUTY  = 5,
  parameter int MAX_DUTY      = MAX_DUTY_DEF,
  parameter int STEP_CYCLES   = 1000,
  parameter int HOLD_CYCLES   = 50000,
  parameter int REPEAT_CYCLES = 20000,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_req,
  input  logic              dec_req,
  input  logic              target_valid,
  input  logic [DUTY_W-1:0] target_duty,
  output logic              inc_pulse,
  output logic              dec_pulse,
  output logic [DUTY_W-1:0] duty_level,
  output logic              busy,
  output logic              at_max,
  output logic              at_min
);

  localparam logic [DUTY_W-1:0] MAX_D       = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] INIT_D      = DUTY_W'(INITIAL_DUTY);
  localparam logic [CNT_W-1:0]  STEP_LOAD   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
    return (d > MAX_D) ? MAX_D : d;
  endfunction

  // Saturating one-level step of the shadow duty.
  function automatic logic [DUTY_W-1:0] step_duty(input logic [DUTY_W-1:0] d,
                                                  input logic              up,
                                                  input logic              dn);
    if (up && (d < MAX_D)) begin
      return d + DUTY_W'(1);
    end else if (dn && (d != '0)) begin
      return d - DUTY_W'(1);
    end
    return d;
  endfunction

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              dir_up_q, dir_up_d;
  logic              inc_pulse_q, dec_pulse_q, busy_q;

  logic              inc_rise, dec_rise;
  logic              both_req, inc_press, dec_press, held, timer_zero;
  logic [DUTY_W-1:0] tgt_in, eff_tgt;
  logic              step_up, step_dn;

  step_edge_detect u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .level (inc_req),
    .rise  (inc_rise)
  );

  step_edge_detect u_dec_edge (
    .clk   (clk),
    .reset (reset),
    .level (dec_req),
    .rise  (dec_rise)
  );

  // Both levels high cancels everything, so a press is only a lone edge.
  assign both_req   = inc_req & dec_req;
  assign inc_press  = inc_rise & ~dec_req;
  assign dec_press  = dec_rise & ~inc_req;
  assign held       = dir_up_q ? inc_req : dec_req;
  assign timer_zero = (timer_q == '0);
  assign tgt_in     = clamp_duty(target_duty);
  // A target written in RAMP takes effect on the same cycle's step decision.
  assign eff_tgt    = target_valid ? tgt_in : target_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    target_d = target_q;
    dir_up_d = dir_up_q;
    step_up  = 1'b0;
    step_dn  = 1'b0;

    if (both_req) begin
      state_d = ST_IDLE;
    end else if ((inc_press || dec_press) &&
                 ((state_q == ST_IDLE) || (state_q == ST_RAMP))) begin
      // A press from IDLE or mid-ramp steps at once and starts hold timing.
      dir_up_d = inc_press;
      step_up  = inc_press;
      step_dn  = dec_press;
      timer_d  = HOLD_LOAD;
      state_d  = ST_HOLD_WAIT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (target_valid) begin
            target_d = tgt_in;
            if (tgt_in != duty_q) begin
              timer_d = STEP_LOAD;
              state_d = ST_RAMP;
            end
          end
        end
        ST_HOLD_WAIT, ST_REPEAT: begin
          if (!held) begin
            state_d = ST_IDLE;
          end else if (timer_zero) begin
            step_up = dir_up_q;
            step_dn = ~dir_up_q;
            timer_d = REPEAT_LOAD;
            state_d = ST_REPEAT;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        ST_RAMP: begin
          target_d = eff_tgt;
          if (timer_zero) begin
            step_up = (eff_tgt > duty_q);
            step_dn = (eff_tgt < duty_q);
            if (step_duty(duty_q, step_up, step_dn) == eff_tgt) begin
              state_d = ST_IDLE;
            end else begin
              timer_d = STEP_LOAD;
            end
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---- registered control and outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      dir_up_q    <= 1'b0;
      duty_q      <= INIT_D;
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      dir_up_q    <= dir_up_d;
      duty_q      <= step_duty(duty_q, step_up, step_dn);
      inc_pulse_q <= step_up && (duty_q < MAX_D);
      dec_pulse_q <= step_dn && (duty_q != '0);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    target_q <= target_d;
  end

  assign inc_pulse  = inc_pulse_q;
  assign dec_pulse  = dec_pulse_q;
  assign duty_level = duty_q;
  assign busy       = busy_q;
  assign at_max     = (duty_q == MAX_D);
  assign at_min     = (duty_q == '0);

endmodule
